shift_fifo_ctrl: RTL and testbench

Control and read stage for the shift-register FIFO. Accepts push/pop requests, issues the single shared shift strobe to the upstream register chain, and consumes that chain's parallel tap bus to present the oldest stored word. Tracks occupancy, flags full/empty/almost-full, and records sticky overflow/underflow errors. Together with the register chain it forms a complete FIFO.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_occ_counter.sv | 36 +++
 rtl/shift_fifo_ctrl.sv | 81 ++++++++
 tb/tb_shift_fifo_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the shift-register FIFO control stage.
package fifo_pkg;

    // Sticky error flags raised by rejected requests.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Width needed to hold an occupancy value of 0..depth inclusive.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// Saturating occupancy counter with empty/full/almost-full decode.
module fifo_occ_counter #(
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int CW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // Count up on a lone accepted push, down on a lone accepted pop, saturating at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != DEPTH_C) begin
            count <= count + ONE_C;
        end else if (dec && !inc && count != '0) begin
            count <= count - ONE_C;
        end
    end

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

endmodule

// File: rtl/shift_fifo_ctrl.sv
// Control and read stage for the shift-register FIFO: accept logic,
// shift strobe, oldest-word mux and sticky error flags.
module shift_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int CW       = cw_of(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        clr_err_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
    output logic                        reg_push_o,
    output logic [WIDTH-1:0]            data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        almost_full_o,
    output logic [CW-1:0]               count_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    logic      pop_ok;
    logic      push_ok;
    fifo_err_t err;

    // A pop needs a stored word; a push needs room unless a pop frees a slot in the same cycle.
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign reg_push_o = push_ok;

    fifo_occ_counter #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .CW        (CW)
    ) u_occ (
        .clk         (clk_i),
        .rst         (rst_i),
        .inc         (push_ok),
        .dec         (pop_ok),
        .count       (count_o),
        .empty       (empty_o),
        .full        (full_o),
        .almost_full (almost_full_o)
    );

    // The oldest word sits at tap count-1; an empty FIFO shows zero regardless of chain contents.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(count_o) == k + 1) begin
                data_o = regs_i[k];
            end
        end
    end

    // Sticky error bits: clear on request, but a new error in the same cycle takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= '0;
        end else begin
            if (clr_err_i) begin
                err <= '0;
            end
            if (push_i && !push_ok) begin
                err.overflow <= 1'b1;
            end
            if (pop_i && !pop_ok) begin
                err.underflow <= 1'b1;
            end
        end
    end

    assign overflow_o  = err.overflow;
    assign underflow_o = err.underflow;

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// Self-checking bench for shift_fifo_ctrl with a register-chain model on regs_i
// and a queue-based reference model of FIFO behaviour.
module tb_shift_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [DEPTH-1:0][WIDTH-1:0] chain = {8'hA5, 8'h5A, 8'hC3, 8'h3C};

    logic             reg_push_o;
    logic [WIDTH-1:0] data_o;
    logic             empty_o;
    logic             full_o;
    logic             almost_full_o;
    logic [2:0]       count_o;
    logic             overflow_o;
    logic             underflow_o;

    int tests  = 0;
    int failed = 0;

    // Reference model state: q[0] is the oldest stored word.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    shift_fifo_ctrl #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (push),
        .pop_i         (pop),
        .clr_err_i     (clr),
        .regs_i        (chain),
        .reg_push_o    (reg_push_o),
        .data_o        (data_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    // Upstream register chain: shifts din in at entry 0 whenever the DUT strobes it.
    always @(posedge clk) begin
        if (reg_push_o) begin
            chain <= {chain[DEPTH-2:0], din};
        end
    end

    // Behavioural FIFO model advanced on each clock edge from the same inputs the DUT sees.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit pop_ok;
            bit push_ok;
            pop_ok  = pop && (q.size() > 0);
            push_ok = push && ((q.size() < DEPTH) || pop_ok);
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && !pop_ok) m_unf = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(din);
        end
    end

    task automatic compareOne(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model in the middle of the cycle.
    task automatic checkOutput();
        int  n;
        bit  exp_push;
        n        = q.size();
        exp_push = push && ((n < DEPTH) || (pop && n > 0));
        compareOne("count",       int'(count_o),       n);
        compareOne("empty",       int'(empty_o),       int'(n == 0));
        compareOne("full",        int'(full_o),        int'(n == DEPTH));
        compareOne("almost_full", int'(almost_full_o), int'(n >= AF));
        compareOne("overflow",    int'(overflow_o),    int'(m_ovf));
        compareOne("underflow",   int'(underflow_o),   int'(m_unf));
        compareOne("data",        int'(data_o),        (n > 0) ? int'(q[0]) : 0);
        compareOne("reg_push",    int'(reg_push_o),    int'(exp_push));
    endtask

    always @(negedge clk) begin
        checkOutput();
    end

    task automatic applyStimulus(input logic p, input logic po, input logic c, input logic [WIDTH-1:0] d);
        push = p;
        pop  = po;
        clr  = c;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] fill_vals[4];
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        applyReset();
        compareOne("lit_reset_count", int'(count_o), 0);
        compareOne("lit_reset_empty", int'(empty_o), 1);
        compareOne("lit_reset_data",  int'(data_o),  0);
        compareOne("lit_reset_errs",  int'({overflow_o, underflow_o}), 0);

        // Fill then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, fill_vals[i]);
            if (i == 2) compareOne("lit_af_at_3", int'(almost_full_o), 1);
        end
        compareOne("lit_full", int'(full_o), 1);
        for (int i = 0; i < 4; i++) begin
            compareOne("lit_drain_data", int'(data_o), int'(fill_vals[i]));
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        end
        compareOne("lit_drained_empty", int'(empty_o), 1);

        // Refill, then overflow at full.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, fill_vals[i]);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h55);
        compareOne("lit_ovf_flag",  int'(overflow_o), 1);
        compareOne("lit_ovf_data",  int'(data_o),     8'h11);
        compareOne("lit_ovf_count", int'(count_o),    4);

        // Push and pop together at full.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        compareOne("lit_pp_data",  int'(data_o),  8'h22);
        compareOne("lit_pp_count", int'(count_o), 4);

        // Clear collides with a new rejected push: error wins.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h66);
        compareOne("lit_clr_vs_err", int'(overflow_o), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        compareOne("lit_clr_ovf", int'(overflow_o), 0);

        // Drain; the last word out is the one pushed alongside a pop.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        compareOne("lit_last_word", int'(data_o), 8'h55);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow, then push+pop when empty.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        compareOne("lit_unf_flag", int'(underflow_o), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h66);
        compareOne("lit_pe_count", int'(count_o),     1);
        compareOne("lit_pe_data",  int'(data_o),      8'h66);
        compareOne("lit_pe_unf",   int'(underflow_o), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        compareOne("lit_clr_unf", int'(underflow_o), 0);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
                applyReset();
                compareOne("lit_midreset_count", int'(count_o), 0);
                compareOne("lit_midreset_data",  int'(data_o),  0);
            end
            applyStimulus(logic'($urandom_range(0, 99) < 55),
                          logic'($urandom_range(0, 99) < 45),
                          logic'($urandom_range(0, 99) < 5),
                          WIDTH'($urandom_range(0, 255)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
